// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and widths for the APB register-file completer
// Widths, the FSM state encoding and the data typedef used by the completer and its register array.
package apb_pkg;

  localparam int APB_DW = 8;
  localparam int APB_AW = 9;

  typedef logic [APB_DW-1:0] apb_data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - DEPTH x 8 flop register array, one write port, one combinational read port
// Addresses at or beyond DEPTH are masked here as well, so an out-of-range index never selects a flop.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int        DEPTH   = 16,
  parameter apb_data_t RST_VAL = 8'h00
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  logic [7:0] waddr,
  input  apb_data_t wdata,
  input  logic [7:0] raddr,
  output apb_data_t rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_data_t regs [0:DEPTH-1];

  logic waddr_ok;
  logic raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < APB_AW'(DEPTH));
  assign raddr_ok = ({1'b0, raddr} < APB_AW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RST_VAL;
      end
    end else if (we && waddr_ok) begin
      regs[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (raddr_ok) begin
      rdata = regs[raddr[IW-1:0]];
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with optional wait states in front of a flop register file
// Outputs are decoded only from registered state, so PADDR/PWDATA never reach PREADY/PRDATA/PSLVERR.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int        DEPTH       = 16,
  parameter int        WAIT_STATES = 0,
  parameter apb_data_t RST_VAL     = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PSEL,
  input  logic       PEN,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  apb_data_t  PWDATA,
  output logic       PREADY,
  output apb_data_t  PRDATA,
  output logic       PSLVERR
);

  apb_state_e state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       latch;

  logic [7:0] addr_q;
  logic       wr_q;
  apb_data_t  wdata_q;

  logic       ready;
  logic       err;
  logic       we;
  apb_data_t  rdata;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (latch) begin
        addr_q  <= PADDR;
        wr_q    <= PWRITE;
        wdata_q <= PWDATA;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (PSEL && !PEN) begin
          state_d = SETUP;
          latch   = 1'b1;
        end
      end
      SETUP: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PEN) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end else begin
          latch = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          // Dropping PSEL while still waiting abandons the transfer before any write
          if (!PSEL) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt - 4'd1;
          end
        end else if (PSEL && !PEN) begin
          state_d = SETUP;
          latch   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Nine-bit compare keeps DEPTH=256 from ever flagging an error
  assign err   = ({1'b0, addr_q} >= APB_AW'(DEPTH));
  assign ready = (state == ACCESS) && (cnt == 4'd0);
  assign we    = ready && wr_q && !err;

  apb_regfile #(
    .DEPTH  (DEPTH),
    .RST_VAL(RST_VAL)
  ) u_regfile (
    .clk  (CLK),
    .rst_n(RST_N),
    .we   (we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(addr_q),
    .rdata(rdata)
  );

  assign PREADY  = ready;
  assign PSLVERR = ready && err;
  assign PRDATA  = (ready && !wr_q && !err) ? rdata : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed bench for apb_slave_regfile over three parameter sets
// Instance 0: DEPTH=16, no waits. Instance 1: DEPTH=256, 2 waits. Instance 2: DEPTH=16, 3 waits, RST_VAL=5C.
module tb_apb_slave_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] psel;
  logic       pen;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [2:0] pready;
  logic [2:0] pslverr;
  logic [7:0] prdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(0), .RST_VAL(8'h00)) u0 (
    .CLK(clk), .RST_N(rst_n), .PSEL(psel[0]), .PEN(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  apb_slave_regfile #(.DEPTH(256), .WAIT_STATES(2), .RST_VAL(8'h00)) u1 (
    .CLK(clk), .RST_N(rst_n), .PSEL(psel[1]), .PEN(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(3), .RST_VAL(8'h5C)) u2 (
    .CLK(clk), .RST_N(rst_n), .PSEL(psel[2]), .PEN(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transfer on instance d; hold=1 leaves PSEL high with PEN low for a back-to-back follow-up.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input logic exp_err, input int ws, input logic hold);
    psel = '0; psel[d] = 1'b1; pen = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    tick();
    check($sformatf("setup_pready d%0d a%h", d, a), {7'b0, pready[d]}, 8'h00);
    pen = 1'b1;
    tick();
    for (int k = 0; k < ws; k++) begin
      check($sformatf("wait_pready d%0d a%h w%0d", d, a, k), {7'b0, pready[d]}, 8'h00);
      check($sformatf("wait_prdata d%0d a%h w%0d", d, a, k), prdata[d], 8'h00);
      paddr = ~a; pwdata = ~wd; pwrite = ~wr;
      tick();
    end
    check($sformatf("ready d%0d a%h", d, a), {7'b0, pready[d]}, 8'h01);
    check($sformatf("pslverr d%0d a%h", d, a), {7'b0, pslverr[d]}, {7'b0, exp_err});
    if (!wr) check($sformatf("prdata d%0d a%h", d, a), prdata[d], exp_rd);
    if (!hold) begin
      psel = '0; pen = 1'b0;
      tick();
      check($sformatf("idle_pready d%0d", d), {7'b0, pready[d]}, 8'h00);
      check($sformatf("idle_prdata d%0d", d), prdata[d], 8'h00);
    end
  endtask

  logic [7:0] m0 [16];

  initial begin
    rst_n = 1'b0; psel = '0; pen = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int i = 0; i < 16; i++) m0[i] = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_pready d%0d", d), {7'b0, pready[d]}, 8'h00);
      check($sformatf("rst_pslverr d%0d", d), {7'b0, pslverr[d]}, 8'h00);
      check($sformatf("rst_prdata d%0d", d), prdata[d], 8'h00);
    end

    // PEN without a setup phase is ignored
    psel[0] = 1'b1; pen = 1'b1;
    tick(); tick();
    check("pen_no_setup", {7'b0, pready[0]}, 8'h00);
    psel = '0; pen = 1'b0;
    tick();

    xfer(0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 0, 1'b0); m0[3] = 8'hA5;
    xfer(0, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 0, 1'b0);
    xfer(0, 1'b1, 8'h0F, 8'hC3, 8'h00, 1'b0, 0, 1'b0); m0[15] = 8'hC3;

    xfer(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2, 1'b0);
    xfer(1, 1'b1, 8'hFF, 8'h96, 8'h00, 1'b0, 2, 1'b0);
    xfer(1, 1'b0, 8'hFF, 8'h00, 8'h96, 1'b0, 2, 1'b0);

    xfer(0, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b1, 0, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 0, 1'b0);

    xfer(0, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0, 0, 1'b1); m0[1] = 8'h11;
    xfer(0, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0, 0, 1'b0);

    for (int i = 0; i < 16; i++) xfer(0, 1'b0, 8'(i), 8'h00, m0[i], 1'b0, 0, 1'b0);

    xfer(2, 1'b1, 8'h02, 8'h3C, 8'h00, 1'b0, 3, 1'b0);
    psel = 3'b100; pen = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'hFF;
    tick();
    pen = 1'b1;
    tick();
    check("abort_access1", {7'b0, pready[2]}, 8'h00);
    tick();
    check("abort_access2", {7'b0, pready[2]}, 8'h00);
    psel = '0; pen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("abort_idle%0d", k), {7'b0, pready[2]}, 8'h00);
    end
    xfer(2, 1'b0, 8'h02, 8'h00, 8'h3C, 1'b0, 3, 1'b0);

    xfer(2, 1'b1, 8'h04, 8'h66, 8'h00, 1'b0, 3, 1'b0);
    psel = 3'b100; pen = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'h77;
    tick();
    pen = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_pready", {7'b0, pready[2]}, 8'h00);
    check("midrst_pslverr", {7'b0, pslverr[2]}, 8'h00);
    check("midrst_prdata", prdata[2], 8'h00);
    psel = '0; pen = 1'b0;
    tick();
    check("midrst_idle_pready", {7'b0, pready[2]}, 8'h00);
    xfer(2, 1'b0, 8'h04, 8'h00, 8'h5C, 1'b0, 3, 1'b0);
    xfer(0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
